// File: rtl/rll_key_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rll_key_sequencer
//  Purpose  : Sequencing controller for a 16-key RLL-locked combinational
//             core. It loads the activation key serially (LSB first) and
//             holds it on the core key inputs. It then runs query
//             transactions: apply a pattern, wait SETTLE cycles, capture
//             the core response and hand it out over a valid/ready port.
//  Ports    : clk, rst (sync, active-high)
//             key_sdi/key_sen/key_commit -> serial key loader
//             key_ready/key_err          <- key status
//             q_valid/q_ready/q_data     -> query handshake
//             core_in/core_key           <- drive the locked core
//             core_out                   -> core response
//             r_valid/r_ready/r_data     <- response handshake
//             busy                       <- FSM not in IDLE
//  Config   : RLL_KEY_PARITY_EN - the loader expects KEY_W+1 bits, and the
//             last bit is even parity over the key.
//  Revision : 1.0 - initial release
// ============================================================================
module rll_key_sequencer #(
    parameter int KEY_W  = 16,
    parameter int IN_W   = 20,
    parameter int OUT_W  = 24,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_sdi,
    input  logic             key_sen,
    input  logic             key_commit,
    output logic             key_ready,
    output logic             key_err,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [IN_W-1:0]  q_data,
    output logic [IN_W-1:0]  core_in,
    output logic [KEY_W-1:0] core_key,
    input  logic [OUT_W-1:0] core_out,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [OUT_W-1:0] r_data,
    output logic             busy
);

`ifdef RLL_KEY_PARITY_EN
    localparam int c_SH_W = KEY_W + 1;
`else
    localparam int c_SH_W = KEY_W;
`endif
    localparam int c_CNT_W  = $clog2(c_SH_W + 1);
    localparam int c_WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_SETTLE  = 2'd1;
    localparam logic [1:0] c_S_CAPTURE = 2'd2;
    localparam logic [1:0] c_S_RESP    = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_SH_W-1:0]   r_sh;
    logic [c_CNT_W-1:0]  r_bit_cnt;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_key_ready;
    logic                r_key_err;
    logic [KEY_W-1:0]    r_core_key;
    logic [IN_W-1:0]     r_core_in;
    logic                r_resp_valid;
    logic [OUT_W-1:0]    r_resp_data;

    logic w_q_ready;
    logic w_busy;
    logic w_commit_idle;
    logic w_frame_full;
    logic w_par_ok;

    assign w_commit_idle = key_commit && (r_state == c_S_IDLE);
    assign w_frame_full  = (r_bit_cnt == c_CNT_W'(c_SH_W));

`ifdef RLL_KEY_PARITY_EN
    // The parity bit is shifted in last, so it sits in the MSB of the frame.
    assign w_par_ok = ((^r_sh[KEY_W-1:0]) == r_sh[KEY_W]);
`else
    assign w_par_ok = 1'b1;
`endif

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_q_ready   = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            c_S_IDLE: begin
                w_busy    = 1'b0;
                w_q_ready = r_key_ready;
                if (q_valid && r_key_ready) w_state_nxt = c_S_SETTLE;
            end
            c_S_SETTLE: begin
                if (r_wait == '0) w_state_nxt = c_S_CAPTURE;
            end
            c_S_CAPTURE: begin
                w_state_nxt = c_S_RESP;
            end
            default: begin
                if (r_ready) w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_sh         <= '0;
            r_bit_cnt    <= '0;
            r_wait       <= '0;
            r_key_ready  <= 1'b0;
            r_key_err    <= 1'b0;
            r_core_key   <= '0;
            r_core_in    <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_key_err <= 1'b0;

            if (key_sen) r_sh <= {key_sdi, r_sh[c_SH_W-1:1]};

            if (w_commit_idle && w_frame_full) begin
                // The commit sees the pre-shift frame. A bit shifted in the
                // same cycle starts the next frame, so the count becomes 1.
                if (w_par_ok) begin
                    r_core_key  <= r_sh[KEY_W-1:0];
                    r_key_ready <= 1'b1;
                end else begin
                    r_key_err <= 1'b1;
                end
                r_bit_cnt <= key_sen ? c_CNT_W'(1) : '0;
            end else begin
                if (w_commit_idle) r_key_err <= 1'b1;
                if (key_sen && !w_frame_full) r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end

            case (r_state)
                c_S_IDLE: begin
                    if (q_valid && w_q_ready) begin
                        r_core_in <= q_data;
                        r_wait    <= c_WAIT_W'(SETTLE - 1);
                    end
                end
                c_S_SETTLE: begin
                    if (r_wait != '0) r_wait <= r_wait - c_WAIT_W'(1);
                end
                c_S_CAPTURE: begin
                    r_resp_data  <= core_out;
                    r_resp_valid <= 1'b1;
                end
                default: begin
                    if (r_ready) r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign key_ready = r_key_ready;
    assign key_err   = r_key_err;
    assign q_ready   = w_q_ready;
    assign core_in   = r_core_in;
    assign core_key  = r_core_key;
    assign r_valid   = r_resp_valid;
    assign r_data    = r_resp_data;
    assign busy      = w_busy;

endmodule
`default_nettype wire

// File: doc/rll_key_sequencer.md
# rll_key_sequencer

Sequencing controller for the 16-key RLL-locked combinational benchmarks (20 inputs, 24 outputs). It loads the activation key over a serial port and holds it stable on the core's key inputs. It then runs query transactions against the locked core: apply a pattern, wait a fixed settle time, capture the response. It sits between the test/oracle harness and any locked `Stat_*`-style netlist, which remains purely combinational.

## Interface
Parameters:
- `KEY_W`, 16, key width; matches the core's `keyIn_0_*` count.
- `IN_W`, 20, core primary input width.
- `OUT_W`, 24, core primary output width.
- `SETTLE`, 2, wait cycles between applying a pattern and sampling the core (≥1).

Ports:
- `clk  in  1`  sole clock, rising edge.
- `rst  in  1`  synchronous, active-high reset.
- `key_sdi  in  1`  serial key bit, LSB first.
- `key_sen  in  1`  shift enable; one bit shifted per cycle while high.
- `key_commit  in  1`  single-cycle strobe; transfers the shift register into the key register.
- `key_ready  out  1`  a valid key has been committed.
- `key_err  out  1`  one-cycle pulse on a rejected commit.
- `q_valid  in  1` / `q_ready  out  1`  query handshake.
- `q_data  in  IN_W`  query pattern.
- `core_in  out  IN_W`  drives core `n1..n20`.
- `core_key  out  KEY_W`  drives core `keyIn_0_0..15`; bit i goes to `keyIn_0_i`.
- `core_out  in  OUT_W`  core outputs, concatenated in declaration order.
- `r_valid  out  1` / `r_ready  in  1`  response handshake.
- `r_data  out  OUT_W`  captured response.
- `busy  out  1`  high in any state other than IDLE.

## Operation
- Reset values:
  - Outputs: `key_ready`, `key_err`, `q_ready`, `r_valid`, `busy` = 0; `core_in`, `core_key`, `r_data` = 0.
  - Internal: shift register = 0, bit counter = 0, state = IDLE.
- Shift register: when `key_sen` is high, `sh <= {key_sdi, sh[KEY_W-1:1]}`. The bit counter increments and saturates at `KEY_W`. Shifting is allowed in every state.
- Commit:
  - Honoured only in IDLE with count == `KEY_W`: `core_key <= sh`, `key_ready <= 1`, count <= 0.
  - Count ≠ `KEY_W`: `key_err` pulses and the key register is unchanged.
  - Commit outside IDLE: silently dropped, no `key_err`.
  - Commit and `key_sen` in the same cycle: the commit uses the pre-shift `sh`. The new bit lands in the cleared counter, so count = 1 afterward.
- FSM:
  - IDLE: `q_ready = key_ready`. On `q_valid & q_ready`, latch `core_in <= q_data` and load cnt = `SETTLE-1`, then go to SETTLE.
  - SETTLE: decrement cnt; when cnt == 0, go to CAPTURE.
  - CAPTURE: `r_data <= core_out`, `r_valid <= 1`, go to RESP.
  - RESP: hold `r_valid` and `r_data` until `r_ready`, then clear `r_valid` and go to IDLE.
- `core_in` holds the last applied pattern in every state; it does not return to 0 between queries.
- A query is never accepted while `key_ready` = 0.

## Timing
- Query accepted at edge k: `core_in` updates at k. `r_valid` rises at edge k+SETTLE+1.
- Throughput: one query per SETTLE+3 cycles when `r_ready` is held high. `r_valid` falls at the edge after `r_ready` is sampled. `q_ready` is high again in the following cycle.
- `r_ready` high before `r_valid` has no effect.
- `rst` mid-transaction: the state, `r_valid`, `key_ready` and `core_key` all clear on the next edge, and any in-flight response is lost.

## Configuration
- `RLL_KEY_PARITY_EN` defined:
  - The loader expects `KEY_W+1` bits. The last bit shifted is even parity over the key.
  - The counter saturates at `KEY_W+1`, and commit requires count == `KEY_W+1`.
  - On a parity mismatch, `key_err` pulses, the key register is unchanged and `key_ready` is unchanged.
- `RLL_KEY_PARITY_EN` undefined: a plain `KEY_W`-bit load with no parity check, as described under Operation.

## Test plan
- Reset, then shift 16 bits of key 0xA5C3 LSB first and commit → `core_key` = 0xA5C3 and `key_ready` = 1 the cycle after the commit, with `key_err` = 0.
- Commit after only 10 shifted bits → `key_err` pulses once; `core_key` stays 0 and `key_ready` stays 0. Then `q_valid` = 1 → `q_ready` stays 0.
- With the key loaded and SETTLE = 2, issue query 0x5_1234 while the core model returns 0xABCDEF → `core_in` = 0x51234 at edge k, `r_valid` = 1 at edge k+3, `r_data` = 0xABCDEF.
- Hold `r_ready` = 0 for 5 cycles while the core output changes → `r_data` stays stable and `q_ready` stays 0. Raising `r_ready` → IDLE next cycle.
- Assert `rst` in SETTLE → on the next edge all outputs are 0 and a subsequent query is refused until a new key is committed.
- With `RLL_KEY_PARITY_EN`, shift key 0x0001 with parity bit 0 → `key_err` pulses. Retry with parity bit 1 → `key_ready` = 1.
